// File: rtl/mux_rr_fifo.sv
// N-channel to 1 multiplexer: one small FIFO per input channel, drained by a
// registered output stage in work-conserving round-robin or fixed-slot TDM order.
module mux_rr_fifo #(
  parameter  int NUM_CH     = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int FIFO_DEPTH = 4,
  parameter  int MODE       = 0,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
  input  logic [NUM_CH-1:0]            valid_in,
  output logic [NUM_CH-1:0]            ready_in,
  input  logic                         ready_out,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         valid_out,
  output logic [CH_W-1:0]              ch_out,
  output logic [NUM_CH-1:0]            overflow
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [NUM_CH-1:0]     nonempty;
  logic [NUM_CH-1:0]     push;
  logic [NUM_CH-1:0]     pop;
  logic [DATA_WIDTH-1:0] head [NUM_CH];

  logic                  advance;
  logic                  sel_found;
  logic [CH_W-1:0]       sel_ch;
  logic [CH_W-1:0]       sel_next;
  logic [CH_W-1:0]       slot_next;
  logic [CH_W-1:0]       rr_ptr_reg;
  logic [CH_W-1:0]       slot_reg;

  assign advance = !valid_out || ready_out;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
      logic [AW-1:0]         wr_ptr_reg;
      logic [AW-1:0]         rd_ptr_reg;
      logic [CW-1:0]         count_reg;
      logic                  overflow_reg;

      // Full is judged on cycle-start occupancy, so a pop never frees a slot for the same edge.
      assign ready_in[gi] = count_reg < CW'(FIFO_DEPTH);
      assign nonempty[gi] = count_reg != '0;
      assign push[gi]     = valid_in[gi] && ready_in[gi];
      assign pop[gi]      = advance && sel_found && (sel_ch == CH_W'(gi));
      assign head[gi]     = mem[rd_ptr_reg];
      assign overflow[gi] = overflow_reg;

      always_ff @(posedge clk) begin
        if (push[gi] && !reset) begin
          mem[wr_ptr_reg] <= data_in[gi*DATA_WIDTH +: DATA_WIDTH];
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          wr_ptr_reg   <= '0;
          rd_ptr_reg   <= '0;
          count_reg    <= '0;
          overflow_reg <= 1'b0;
        end else begin
          if (push[gi]) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
          end
          if (pop[gi]) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
          end
          case ({push[gi], pop[gi]})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
          endcase
          if (valid_in[gi] && !ready_in[gi]) begin
            overflow_reg <= 1'b1;
          end
        end
      end
    end
  endgenerate

  // Grant selection: rotating priority scan from rr_ptr, or the single TDM slot.
  always_comb begin : sel_comb
    int              idx;
    logic [CH_W-1:0] cand;
    sel_found = 1'b0;
    sel_ch    = '0;
    idx       = 0;
    cand      = '0;
    if (MODE == 0) begin
      for (int k = 0; k < NUM_CH; k++) begin
        idx = int'(rr_ptr_reg) + k;
        if (idx >= NUM_CH) begin
          idx = idx - NUM_CH;
        end
        cand = CH_W'(idx);
        if (!sel_found && nonempty[cand]) begin
          sel_found = 1'b1;
          sel_ch    = cand;
        end
      end
    end else begin
      sel_found = nonempty[slot_reg];
      sel_ch    = slot_reg;
    end
  end

  assign sel_next  = (sel_ch == CH_W'(NUM_CH - 1)) ? '0 : sel_ch + CH_W'(1);
  assign slot_next = (slot_reg == CH_W'(NUM_CH - 1)) ? '0 : slot_reg + CH_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out   <= '0;
      valid_out  <= 1'b0;
      ch_out     <= '0;
      rr_ptr_reg <= '0;
      slot_reg   <= '0;
    end else if (advance) begin
      valid_out <= sel_found;
      data_out  <= sel_found ? head[sel_ch] : '0;
      if (MODE == 0) begin
        // An idle round-robin cycle keeps the last source and scan position.
        if (sel_found) begin
          ch_out     <= sel_ch;
          rr_ptr_reg <= sel_next;
        end
      end else begin
        ch_out   <= slot_reg;
        slot_reg <= slot_next;
      end
    end
  end

endmodule

// File: tb/tb_mux_rr_fifo.sv
// Directed bench for mux_rr_fifo: a round-robin instance and a TDM instance,
// with a queue scoreboard per instance checked by a negedge monitor.
module tb_mux_rr_fifo;

  typedef struct packed {
    logic [1:0] ch;
    logic [7:0] data;
  } exp_t;

  logic        clk = 1'b0;
  int          checks = 0;
  int          errors = 0;
  exp_t        q0[$];
  exp_t        q1[$];
  exp_t        e0;
  exp_t        e1;

  logic        reset0, reset1;
  logic [31:0] data_in0, data_in1;
  logic [3:0]  valid_in0, valid_in1;
  logic [3:0]  ready_in0, ready_in1;
  logic        ready_out0, ready_out1;
  logic [7:0]  data_out0, data_out1;
  logic        valid_out0, valid_out1;
  logic [1:0]  ch_out0, ch_out1;
  logic [3:0]  overflow0, overflow1;

  always #5 clk = ~clk;

  mux_rr_fifo #(.NUM_CH(4), .DATA_WIDTH(8), .FIFO_DEPTH(4), .MODE(0)) dut_rr (
    .clk(clk), .reset(reset0), .data_in(data_in0), .valid_in(valid_in0),
    .ready_in(ready_in0), .ready_out(ready_out0), .data_out(data_out0),
    .valid_out(valid_out0), .ch_out(ch_out0), .overflow(overflow0)
  );

  mux_rr_fifo #(.NUM_CH(4), .DATA_WIDTH(8), .FIFO_DEPTH(4), .MODE(1)) dut_tdm (
    .clk(clk), .reset(reset1), .data_in(data_in1), .valid_in(valid_in1),
    .ready_in(ready_in1), .ready_out(ready_out1), .data_out(data_out1),
    .valid_out(valid_out1), .ch_out(ch_out1), .overflow(overflow1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle0(input string tag);
    check({tag, "_data"}, 32'(data_out0), 32'h0);
    check({tag, "_valid"}, 32'(valid_out0), 32'h0);
    check({tag, "_ch"}, 32'(ch_out0), 32'h0);
    check({tag, "_ovf"}, 32'(overflow0), 32'h0);
    check({tag, "_rdy"}, 32'(ready_in0), 32'hF);
  endtask

  task automatic drain0(input string tag);
    for (int i = 0; i < 40 && q0.size() != 0; i++) begin
      @(posedge clk);
    end
    #1;
    check({tag, "_drained"}, 32'(q0.size()), 32'h0);
  endtask

  // Monitors: a word is consumed on the edge following a negedge where valid && ready.
  always @(negedge clk) begin
    if (!reset0 && valid_out0 && ready_out0) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb0_unexpected: got ch=%0d data=0x%02h required no word", ch_out0, data_out0);
      end else begin
        e0 = q0.pop_front();
        $display("xfer rr  ch=%0d data=0x%02h (exp ch=%0d data=0x%02h)", ch_out0, data_out0, e0.ch, e0.data);
        check("sb0_data", 32'(data_out0), 32'(e0.data));
        check("sb0_ch", 32'(ch_out0), 32'(e0.ch));
      end
    end
  end

  always @(negedge clk) begin
    if (!reset1 && valid_out1 && ready_out1) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb1_unexpected: got ch=%0d data=0x%02h required no word", ch_out1, data_out1);
      end else begin
        e1 = q1.pop_front();
        $display("xfer tdm ch=%0d data=0x%02h (exp ch=%0d data=0x%02h)", ch_out1, data_out1, e1.ch, e1.data);
        check("sb1_data", 32'(data_out1), 32'(e1.data));
        check("sb1_ch", 32'(ch_out1), 32'(e1.ch));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset0 = 1'b1; reset1 = 1'b1;
    data_in0 = '0; data_in1 = '0;
    valid_in0 = '0; valid_in1 = '0;
    ready_out0 = 1'b0; ready_out1 = 1'b0;

    // Reset and idle
    tick(); check_idle0("rst0");
    tick(); check_idle0("rst1");
    reset0 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(); check_idle0("idle");
    end

    // Round-robin fairness between ch0 and ch1
    ready_out0 = 1'b1;
    valid_in0 = 4'b0011; data_in0[7:0] = 8'h11; data_in0[15:8] = 8'hFF;
    q0.push_back('{2'd0, 8'h11}); q0.push_back('{2'd1, 8'hFF});
    tick();
    check("rr_lat0_valid", 32'(valid_out0), 32'h0);
    data_in0[7:0] = 8'h12; data_in0[15:8] = 8'hFE;
    q0.push_back('{2'd0, 8'h12}); q0.push_back('{2'd1, 8'hFE});
    tick();
    check("rr_lat1_valid", 32'(valid_out0), 32'h1);
    check("rr_lat1_data", 32'(data_out0), 32'h11);
    data_in0[7:0] = 8'h13; data_in0[15:8] = 8'hFD;
    q0.push_back('{2'd0, 8'h13}); q0.push_back('{2'd1, 8'hFD});
    tick();
    valid_in0 = '0;
    for (int i = 0; i < 5; i++) tick();
    check("rr_end_valid", 32'(valid_out0), 32'h0);
    check("rr_end_drained", 32'(q0.size()), 32'h0);

    // Overflow on ch2 under backpressure
    ready_out0 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      valid_in0 = 4'b0100;
      data_in0[23:16] = 8'h20 + 8'(i);
      if (i < 5) q0.push_back('{2'd2, 8'h20 + 8'(i)});
      if (i == 5) check("ovf_rdy_before_drop", 32'(ready_in0), 32'hB);
      tick();
      if (i == 4) check("ovf_none_yet", 32'(overflow0), 32'h0);
    end
    valid_in0 = '0;
    check("ovf_flag", 32'(overflow0), 32'h4);
    check("ovf_head_data", 32'(data_out0), 32'h20);
    ready_out0 = 1'b1;
    drain0("ovf");
    tick();
    check("ovf_sticky", 32'(overflow0), 32'h4);
    check("ovf_idle_valid", 32'(valid_out0), 32'h0);

    // Backpressure hold with 0x1B presented
    ready_out0 = 1'b0;
    valid_in0 = 4'b0010; data_in0[15:8] = 8'h1B;
    q0.push_back('{2'd1, 8'h1B});
    tick();
    data_in0[15:8] = 8'h1C;
    q0.push_back('{2'd1, 8'h1C});
    tick();
    valid_in0 = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_data", 32'(data_out0), 32'h1B);
      check("hold_ch", 32'(ch_out0), 32'h1);
      check("hold_valid", 32'(valid_out0), 32'h1);
    end
    ready_out0 = 1'b1;
    tick();
    check("hold_next_data", 32'(data_out0), 32'h1C);
    check("hold_next_valid", 32'(valid_out0), 32'h1);
    drain0("hold");

    // Reset mid-stream
    ready_out0 = 1'b0;
    tick();
    valid_in0 = 4'b1001; data_in0[7:0] = 8'hA0; data_in0[31:24] = 8'hB0;
    tick();
    valid_in0 = 4'b0001; data_in0[7:0] = 8'hA1;
    tick();
    check("mid_pre_valid", 32'(valid_out0), 32'h1);
    reset0 = 1'b1; ready_out0 = 1'b1;
    valid_in0 = 4'b1111; data_in0 = 32'hC3C2C1C0;
    tick();
    check_idle0("mid_rst");
    reset0 = 1'b0; valid_in0 = '0;
    for (int i = 0; i < 3; i++) begin
      tick(); check("mid_empty_valid", 32'(valid_out0), 32'h0);
    end
    valid_in0 = 4'b0100; data_in0[23:16] = 8'h5A;
    q0.push_back('{2'd2, 8'h5A});
    tick();
    valid_in0 = '0;
    check("mid_first_lat0", 32'(valid_out0), 32'h0);
    tick();
    check("mid_first_valid", 32'(valid_out0), 32'h1);
    check("mid_first_data", 32'(data_out0), 32'h5A);
    check("mid_first_ch", 32'(ch_out0), 32'h2);
    drain0("mid");

    // TDM: only ch3 holds 0xED
    reset1 = 1'b0; ready_out1 = 1'b1;
    valid_in1 = 4'b1000; data_in1[31:24] = 8'hED;
    q1.push_back('{2'd3, 8'hED});
    for (int k = 0; k < 12; k++) begin
      tick();
      valid_in1 = '0;
      check("tdm_ch", 32'(ch_out1), 32'(k % 4));
      check("tdm_valid", 32'(valid_out1), (k == 3) ? 32'h1 : 32'h0);
      check("tdm_data", 32'(data_out1), (k == 3) ? 32'hED : 32'h0);
    end
    check("tdm_drained", 32'(q1.size()), 32'h0);
    check("tdm_ovf", 32'(overflow1), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_rr_fifo.md
Name: mux_rr_fifo

Overview:
- Parametrised N-channel to 1 multiplexer; successor to the 2:1 valid-qualified 8-bit mux.
- Each input channel feeds its own small FIFO. A registered output stage drains the FIFOs in one of two modes:
  - work-conserving round-robin, or
  - fixed-slot TDM.
- Sits between the per-lane byte sources and the serialising datapath, on a single clock domain.

Parameters:
- NUM_CH, 4, number of input channels (2..16).
- DATA_WIDTH, 8, bits per word.
- FIFO_DEPTH, 4, words per channel FIFO; power of 2, at least 2.
- MODE, 0, 0 = round-robin skipping empty channels; 1 = fixed TDM slot per channel.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- data_in  in  NUM_CH*DATA_WIDTH  channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- valid_in  in  NUM_CH  per-channel write strobe.
- ready_in  out  NUM_CH  per-channel "FIFO not full", combinational from occupancy.
- ready_out  in  1  downstream accepts the output word this cycle.
- data_out  out  DATA_WIDTH  registered output word.
- valid_out  out  1  registered output qualifier.
- ch_out  out  CH_W = max(1, clog2(NUM_CH))  source channel of the current data_out/slot.
- overflow  out  NUM_CH  sticky per-channel drop flag.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values:
  - all FIFOs empty;
  - rr pointer = 0, TDM slot = 0;
  - data_out = 0, valid_out = 0, ch_out = 0, overflow = 0.
- Reset asserted mid-operation discards all buffered words. It takes priority over every push and pop in that cycle.
- Write side:
  - Push on channel i when valid_in[i] && ready_in[i].
  - ready_in[i] = (count[i] < FIFO_DEPTH), using occupancy at cycle start.
  - No same-cycle write-through when full, even if a pop occurs in the same cycle.
  - valid_in[i] && !ready_in[i]: word dropped, overflow[i] <= 1. It stays 1 until reset.
  - Counter widths: clog2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.
- Output stage advance:
  - advance = !valid_out || ready_out.
  - If !advance, data_out, valid_out and ch_out hold and no FIFO pops.
- MODE 0 (round-robin):
  - On advance, scan channels ptr, ptr+1, … (mod NUM_CH) using cycle-start occupancy.
  - First non-empty channel g: pop, data_out <= head[g], ch_out <= g, valid_out <= 1, ptr <= (g+1) mod NUM_CH.
  - None non-empty: valid_out <= 0, data_out <= 0, ch_out and ptr unchanged.
- MODE 1 (TDM):
  - On advance, consider channel slot only.
  - Non-empty: pop, valid_out <= 1, data_out <= head.
  - Empty: valid_out <= 0, data_out <= 0.
  - ch_out <= slot in both cases; slot <= (slot+1) mod NUM_CH every advance.
- Latency: word pushed at edge t is at the FIFO head after t. It earliest appears on valid_out/data_out after edge t+1 (one cycle minimum, no bypass).
- Simultaneous push and pop on the same channel: count unchanged; both take effect.
- Throughput: one word per cycle while ready_out = 1 and any eligible FIFO is non-empty.
- Ordering: per-channel FIFO order always preserved. No word is duplicated or lost except overflow drops.

Test Plan:
- Reset and idle (NUM_CH=4, DEPTH=4, MODE 0): hold reset 2 cycles, then all inputs idle 10 cycles -> all outputs 0, ready_in = 4'b1111 throughout.
- RR fairness:
  - Stimulus: ch0 pushes 0x11,0x12,0x13; ch1 pushes 0xFF,0xFE,0xFD in the same cycles; ready_out = 1.
  - Response: output sequence 0x11(ch0), 0xFF(ch1), 0x12, 0xFE, 0x13, 0xFD.
  - First valid_out one cycle after the first push. valid_out = 0 after the sixth word.
- Overflow: ready_out = 0 and ch2 pushes 0x20..0x25 on consecutive cycles.
  - After the first word 0x20 moves into the output register, ch2 buffers 0x21..0x24.
  - ready_in[2] drops after 0x24 is accepted; 0x25 is dropped and overflow = 4'b0100.
  - Raising ready_out yields 0x20..0x24 in order. overflow stays set until reset.
- Backpressure hold: valid_out = 1 with data 0x1B; ready_out = 0 for 5 cycles -> data_out/ch_out/valid_out stable, no FIFO count change. Next word presented the cycle after ready_out = 1.
- TDM mode (MODE 1): only ch3 holds 0xED.
  - ch_out cycles 0,1,2,3,0,… every cycle.
  - valid_out = 1 only in the ch3 slot, with data 0xED; all other slots have valid_out = 0, data_out = 0.
- Reset mid-stream: FIFOs partially full, valid_out = 1 and pushes active in the same cycle as reset -> next cycle all counts 0, outputs 0. The first post-reset word pushed appears after one cycle.
